// File: rtl/serdes_pkg.sv
// Shared definitions for the PISO serializer and its downstream SIPO partner.
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } serdes_state_e;

  localparam int unsigned SERDES_WIDTH = 4;
  localparam int unsigned SERDES_GAP   = 0;

  // Gap counter is fixed at 4 bits, enough for the 0..15 gap range.
  localparam int unsigned SERDES_GAP_CNT_W = 4;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-word handshake plus serial frame outputs of the PISO serializer.
interface piso_serializer_if
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH = SERDES_WIDTH
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  // Upstream word source that also observes the serial stream.
  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  sout_last,
    input  busy
  );

  // The serializer itself.
  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output sout_last,
    output busy
  );

endinterface

// File: rtl/piso_shift_reg.sv
// Loadable shift register; presents the next bit to send on sout.
module piso_shift_reg #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sreg_q;

  // Load wins over shift so a back-to-back word replaces the spent one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
    end else if (load) begin
      sreg_q <= din;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
      end else begin
        sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
      end
    end
  end

  assign sout = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: valid/ready word in, framed bit stream out.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH      = SERDES_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = SERDES_GAP
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [SERDES_GAP_CNT_W-1:0] GapLast = SERDES_GAP_CNT_W'(GAP_CYCLES - 1);

  serdes_state_e               state_q;
  logic [CntW-1:0]             bit_cnt_q;
  logic [CntW-1:0]             bit_cnt_inc;
  logic [SERDES_GAP_CNT_W-1:0] gap_cnt_q;
  logic                        din_ready_q;
  logic                        sout_valid_q;
  logic                        sout_last_q;
  logic                        busy_q;
  logic                        accept;
  logic                        sreg_bit;

  // din_ready comes straight from a flop, so accept never loops back into it.
  assign accept      = bus.din_valid & din_ready_q;
  assign bit_cnt_inc = bit_cnt_q + 1'b1;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state_q == SHIFT),
    .din   (bus.din),
    .sout  (sreg_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      din_ready_q  <= 1'b1;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= SHIFT;
            bit_cnt_q    <= '0;
            din_ready_q  <= 1'b0;
            sout_valid_q <= 1'b1;
            sout_last_q  <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt_q == CntLast) begin
            bit_cnt_q <= '0;
            if (GAP_CYCLES != 0) begin
              state_q      <= GAP;
              gap_cnt_q    <= '0;
              din_ready_q  <= 1'b0;
              sout_valid_q <= 1'b0;
              sout_last_q  <= 1'b0;
              busy_q       <= 1'b1;
            end else if (accept) begin
              state_q      <= SHIFT;
              din_ready_q  <= 1'b0;
              sout_valid_q <= 1'b1;
              sout_last_q  <= 1'b0;
              busy_q       <= 1'b1;
            end else begin
              state_q      <= IDLE;
              din_ready_q  <= 1'b1;
              sout_valid_q <= 1'b0;
              sout_last_q  <= 1'b0;
              busy_q       <= 1'b0;
            end
          end else begin
            bit_cnt_q   <= bit_cnt_inc;
            sout_last_q <= (bit_cnt_inc == CntLast);
            // Open the handshake on the final bit only when frames may abut.
            din_ready_q <= (bit_cnt_inc == CntLast) && (GAP_CYCLES == 0);
          end
        end
        GAP: begin
          if (gap_cnt_q == GapLast) begin
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            din_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          din_ready_q  <= 1'b1;
          sout_valid_q <= 1'b0;
          sout_last_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Gating with the valid flop keeps sout at 0 outside frames.
  assign bus.sout       = sout_valid_q & sreg_bit;
  assign bus.sout_valid = sout_valid_q;
  assign bus.sout_last  = sout_last_q;
  assign bus.din_ready  = din_ready_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations, timeline model plus directed vectors.
module tb_piso_serializer;
  import serdes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] din_s [3];
  logic [2:0]  dv_s;
  logic [2:0]  rdy_s, val_s, so_s, last_s, busy_s;

  int vectors = 0;
  int misses  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance 0: W=4 MSB-first no gap; 1: W=4 LSB-first gap 2; 2: W=2 MSB-first no gap.
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned W    = (g == 2) ? 2 : SERDES_WIDTH;
    localparam bit          MSB  = (g != 1);
    localparam int unsigned GAPC = (g == 1) ? 2 : SERDES_GAP;
    localparam int          WI   = W;
    localparam int          GI   = GAPC;

    piso_serializer_if #(.WIDTH(W)) bus ();

    piso_serializer #(
      .WIDTH      (W),
      .MSB_FIRST  (MSB),
      .GAP_CYCLES (GAPC)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.din       = din_s[g][W-1:0];
    assign bus.din_valid = dv_s[g];
    assign rdy_s[g]      = bus.din_ready;
    assign val_s[g]      = bus.sout_valid;
    assign so_s[g]       = bus.sout;
    assign last_s[g]     = bus.sout_last;
    assign busy_s[g]     = bus.busy;

    // Timeline model: a word accepted at edge N owns cycles N..N+W-1, then GI idle
    // cycles, and the handshake reopens at a cycle computed by plain arithmetic.
    int          e       = 0;
    int          acc     = -100;
    int          free_at = 0;
    bit          armed   = 1'b0;
    logic [31:0] word    = '0;

    always @(posedge clk) begin
      e = e + 1;
      if (rst) begin
        armed   = 1'b1;
        acc     = -100;
        free_at = e;
      end else if (armed && dv_s[g] && (e - 1 >= free_at)) begin
        acc     = e;
        word    = din_s[g];
        free_at = (GI == 0) ? e + WI - 1 : e + WI + GI;
      end
    end

    always @(negedge clk) begin
      int k;
      bit inf;
      logic ebit;
      logic [4:0] exp_t;
      if (armed) begin
        k    = e - acc;
        inf  = (k >= 0) && (k < WI);
        ebit = 1'b0;
        if (inf) ebit = MSB ? word[WI-1-k] : word[k];
        exp_t = {e >= free_at, inf, ebit, inf && (k == WI - 1),
                 (e >= acc) && (e <= acc + WI - 1 + GI)};
        chk($sformatf("inst%0d_cyc%0d_rdy_val_sout_last_busy", g, e),
            {27'd0, rdy_s[g], val_s[g], so_s[g], last_s[g], busy_s[g]}, {27'd0, exp_t});
      end
    end
  end

  typedef struct {
    int         inst;
    logic [3:0] word;
    logic [3:0] stream;  // bit 3 is the first bit on the wire
  } vec_t;

  vec_t tbl [8];

  task automatic send(input int i, input logic [31:0] w);
    bit done = 1'b0;
    din_s[i] = w;
    dv_s[i]  = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      if (rdy_s[i]) done = 1'b1;
      tick();
    end
    dv_s[i] = 1'b0;
    if (!done) begin
      vectors++;
      misses++;
      $display("FAIL send_timeout inst%0d: din_ready never rose, expected within 40 cycles", i);
    end
  endtask

  task automatic collect(input int i, input int n, output logic [31:0] bits,
                         output logic [31:0] vm, output logic [31:0] lm);
    bits = '0; vm = '0; lm = '0;
    for (int k = 0; k < n; k++) begin
      bits = {bits[30:0], so_s[i]};
      vm   = {vm[30:0], val_s[i]};
      lm   = {lm[30:0], last_s[i]};
      tick();
    end
  endtask

  initial begin
    logic [31:0] bits, vm, lm, rm;

    tbl[0] = '{0, 4'b1011, 4'b1011};
    tbl[1] = '{0, 4'b1100, 4'b1100};
    tbl[2] = '{0, 4'b0110, 4'b0110};
    tbl[3] = '{0, 4'b0001, 4'b0001};
    tbl[4] = '{1, 4'b0011, 4'b1100};
    tbl[5] = '{1, 4'b1000, 4'b0001};
    tbl[6] = '{1, 4'b1101, 4'b1011};
    tbl[7] = '{1, 4'b0100, 4'b0010};

    for (int i = 0; i < 3; i++) din_s[i] = '0;
    dv_s = '0;
    rst  = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_state", {23'd0, rdy_s, val_s, busy_s}, {23'd0, 3'b111, 3'b000, 3'b000});

    // Single frames from the table.
    for (int n = 0; n < 8; n++) begin
      send(tbl[n].inst, {28'd0, tbl[n].word});
      collect(tbl[n].inst, 4, bits, vm, lm);
      chk($sformatf("tbl%0d_bits", n), bits, {28'd0, tbl[n].stream});
      chk($sformatf("tbl%0d_valid", n), vm, 32'hF);
      chk($sformatf("tbl%0d_last", n), lm, 32'b0001);
      repeat (4) tick();
    end

    // Back-to-back frames with din_valid held.
    din_s[0] = 32'b1100;
    dv_s[0]  = 1'b1;
    tick();
    din_s[0] = 32'b0110;
    bits = '0; vm = '0; rm = '0;
    for (int k = 0; k < 8; k++) begin
      bits = {bits[30:0], so_s[0]};
      vm   = {vm[30:0], val_s[0]};
      rm   = {rm[30:0], rdy_s[0]};
      tick();
      if (k == 3) dv_s[0] = 1'b0;
    end
    chk("b2b_bits", bits, 32'b1100_0110);
    chk("b2b_valid", vm, 32'hFF);
    chk("b2b_ready", rm, 32'b0001_0001);
    repeat (3) tick();

    // din_valid while busy is ignored.
    send(0, 32'b0001);
    bits = '0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin din_s[0] = 32'hF; dv_s[0] = 1'b1; end
      if (k == 3) dv_s[0] = 1'b0;
      bits = {bits[30:0], so_s[0]};
      tick();
    end
    collect(0, 3, rm, vm, lm);
    chk("busy_ignore_bits", bits, 32'b0001);
    chk("busy_ignore_no_frame", vm, 32'b000);
    repeat (2) tick();

    // Reset mid-frame, with din_valid high during the reset edge.
    send(0, 32'b1010);
    bits = {31'd0, so_s[0]};
    tick();
    bits = {bits[30:0], so_s[0]};
    rst      = 1'b1;
    dv_s[0]  = 1'b1;
    din_s[0] = 32'hF;
    tick();
    rst     = 1'b0;
    dv_s[0] = 1'b0;
    chk("rst_partial_bits", bits, 32'b10);
    chk("rst_outputs", {27'd0, val_s[0], so_s[0], last_s[0], rdy_s[0], busy_s[0]},
        {27'd0, 5'b00010});
    tick();
    chk("rst_no_accept", {31'd0, val_s[0]}, 32'd0);
    repeat (2) tick();

    // Gap mode: two queued words on the LSB-first, gap-2 instance.
    din_s[1] = 32'b1001;
    dv_s[1]  = 1'b1;
    tick();
    din_s[1] = 32'b0110;
    bits = '0; vm = '0; rm = '0;
    for (int k = 0; k < 11; k++) begin
      bits = {bits[30:0], so_s[1]};
      vm   = {vm[30:0], val_s[1]};
      rm   = {rm[30:0], rdy_s[1]};
      tick();
      if (k == 6) dv_s[1] = 1'b0;
    end
    chk("gap_bits", bits, 32'b1001_000_0110);
    chk("gap_valid", vm, 32'b1111_000_1111);
    chk("gap_ready", rm, 32'b0000_001_0000);
    repeat (4) tick();

    // Two-bit words streamed continuously.
    dv_s[2] = 1'b1;
    vm = '0; rm = '0;
    for (int k = 0; k < 8; k++) begin
      din_s[2] = $urandom;
      vm = {vm[30:0], val_s[2]};
      rm = {rm[30:0], rdy_s[2]};
      tick();
    end
    dv_s[2] = 1'b0;
    chk("w2_stream_valid", vm, 32'b0111_1111);
    chk("w2_stream_ready", rm, 32'b1010_1010);
    repeat (3) tick();

    // Random traffic with occasional resets, checked by the timeline model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        dv_s[i]  = ($urandom_range(0, 3) != 0);
        din_s[i] = $urandom;
      end
      rst = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst  = 1'b0;
    dv_s = '0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
